// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receives start/data/stop serial frames (one bit per clock,
// data LSB first) and presents each word on a valid/ready parallel output.
// Framing errors and overruns are reported on sticky flags.
//
// Optional build macro: PARITY_CHECK_EN
//   When defined, each frame carries an even-parity bit between the last data
//   bit and the stop bit, and a sticky parity_err output is added.
module serial_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun,
  input  logic              err_clr
`ifdef PARITY_CHECK_EN
  ,
  output logic              parity_err
`endif
);

  // Counter only has to reach DATA_W-1.
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] shreg_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              room_s;
  logic              par_fail_s;

`ifdef PARITY_CHECK_EN
  logic              par_bit_r;

  // Even parity: data bits XOR parity bit must be zero.
  function automatic logic even_parity_ok(input logic [DATA_W-1:0] d, input logic p);
    return ((^d) ^ p) == 1'b0;
  endfunction

  assign par_fail_s = ~even_parity_ok(shreg_r, par_bit_r);
`else
  assign par_fail_s = 1'b0;
`endif

  // The output register can accept a word if empty or being drained this edge.
  assign room_s = ~dout_valid | dout_ready;

  // Frame FSM, shift register, output register and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      cnt_r      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_bit_r  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      // Consumer handshake; a load in STOP below may override this clear.
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end

      // Flag clear comes first so that a same-edge set below wins.
      if (err_clr) begin
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
        parity_err <= 1'b0;
`endif
      end

      case (state_r)
        IDLE: begin
          if (!din) begin
            state_r <= DATA;
            cnt_r   <= '0;
          end else begin
            state_r <= IDLE;
          end
        end

        DATA: begin
          shreg_r <= {din, shreg_r[DATA_W-1:1]};
          if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
`ifdef PARITY_CHECK_EN
            state_r <= PAR;
`else
            state_r <= STOP;
`endif
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        PAR: begin
`ifdef PARITY_CHECK_EN
          par_bit_r <= din;
          state_r   <= STOP;
`else
          // Unreachable without parity; recover to a known state.
          state_r   <= IDLE;
`endif
        end

        STOP: begin
          if (din) begin
            if (par_fail_s) begin
`ifdef PARITY_CHECK_EN
              parity_err <= 1'b1;
`endif
            end else if (room_s) begin
              dout       <= shreg_r;
              dout_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            // Bad stop bit: word dropped, and the 0 is not a new start bit.
            frame_err <= 1'b1;
`ifdef PARITY_CHECK_EN
            if (par_fail_s) begin
              parity_err <= 1'b1;
            end
`endif
          end
          state_r <= IDLE;
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx (DATA_W=8). Expected words are
// queued when a good frame is sent and compared when the DUT hands them over.
module tb_serial_frame_rx;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
`ifdef PARITY_CHECK_EN
  logic       parity_err;
`endif

  int checks_cnt = 0;
  int errors_cnt = 0;
  logic [7:0] exp_q[$];

  serial_frame_rx #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
`ifdef PARITY_CHECK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: a word transferring at the next edge must match the queue head.
  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_word", {24'd0, dout}, 32'hFFFF_FFFF);
      end else begin
        check_eq("sb_word", {24'd0, dout}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef PARITY_CHECK_EN
    send_bit(par);
`endif
    send_bit(stop);
    din = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    din        = 1'b1;
    dout_ready = 1'b0;
    err_clr    = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle line after reset
    idle(20);
    check_eq("rst_valid", {31'd0, dout_valid}, 32'd0);
    check_eq("rst_dout", {24'd0, dout}, 32'd0);
    check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);

    // Single frame 0xA5, consumer ready
    dout_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h01) != 8'h00);
`ifdef PARITY_CHECK_EN
    send_bit(^(8'hA5));
`endif
    check_eq("a5_valid_before_stop", {31'd0, dout_valid}, 32'd0);
    send_bit(1'b1);
    check_eq("a5_valid_after_stop", {31'd0, dout_valid}, 32'd1);
    check_eq("a5_dout", {24'd0, dout}, 32'h0000_00A5);
    idle(1);
    check_eq("a5_valid_one_cycle", {31'd0, dout_valid}, 32'd0);
    idle(2);

    // Back-to-back 0x3C, 0xC3 with consumer stalled -> overrun
    dout_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, ^(8'h3C), 1'b1);
    check_eq("b2b_overrun_mid", {31'd0, overrun}, 32'd0);
    send_frame(8'hC3, ^(8'hC3), 1'b1);
    check_eq("b2b_dout_held", {24'd0, dout}, 32'h0000_003C);
    check_eq("b2b_valid_held", {31'd0, dout_valid}, 32'd1);
    check_eq("b2b_overrun", {31'd0, overrun}, 32'd1);
    idle(3);
    check_eq("b2b_stable_dout", {24'd0, dout}, 32'h0000_003C);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    check_eq("b2b_valid_drained", {31'd0, dout_valid}, 32'd0);
    check_eq("b2b_overrun_sticky", {31'd0, overrun}, 32'd1);
    pulse_err_clr();
    check_eq("b2b_overrun_cleared", {31'd0, overrun}, 32'd0);

    // Bad stop bit, then a good frame immediately after
    dout_ready = 1'b1;
    send_frame(8'h5A, ^(8'h5A), 1'b0);
    check_eq("ferr_set", {31'd0, frame_err}, 32'd1);
    check_eq("ferr_no_valid", {31'd0, dout_valid}, 32'd0);
    exp_q.push_back(8'h01);
    send_frame(8'h01, ^(8'h01), 1'b1);
    check_eq("ferr_next_valid", {31'd0, dout_valid}, 32'd1);
    check_eq("ferr_next_dout", {24'd0, dout}, 32'h0000_0001);
    check_eq("ferr_still_set", {31'd0, frame_err}, 32'd1);
    idle(2);
    pulse_err_clr();
    check_eq("ferr_cleared", {31'd0, frame_err}, 32'd0);

    // Reset in the middle of a frame of 0xFF, then 0x81
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_dout", {24'd0, dout}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    check_eq("midrst_no_valid", {31'd0, dout_valid}, 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, ^(8'h81), 1'b1);
    check_eq("midrst_dout_81", {24'd0, dout}, 32'h0000_0081);
    idle(2);
    check_eq("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check_eq("midrst_overrun", {31'd0, overrun}, 32'd0);

`ifdef PARITY_CHECK_EN
    // Parity good then parity bad
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    check_eq("par_good_dout", {24'd0, dout}, 32'h0000_0007);
    check_eq("par_good_flag", {31'd0, parity_err}, 32'd0);
    idle(2);
    send_frame(8'h07, 1'b0, 1'b1);
    check_eq("par_bad_flag", {31'd0, parity_err}, 32'd1);
    check_eq("par_bad_no_valid", {31'd0, dout_valid}, 32'd0);
    check_eq("par_bad_no_overrun", {31'd0, overrun}, 32'd0);
    idle(2);
`endif

    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
